// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer for load-use, branch, mem wait and mul/div.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
  parameter int MD_CYCLES = 32
`ifdef HAZARD_PERF_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       r,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_r,
  output logic       id_ex_en,
  output logic       id_ex_r,
  output logic       ex_mem_en,
  output logic       ex_mem_r,
  output logic       mem_wb_en,
  output logic       mem_wb_r,
  output logic       md_go,
  output logic       md_busy
`ifdef HAZARD_PERF_EN
  ,output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  typedef enum logic {RUN, MD_WAIT} state_t;
  state_t state;
  logic [7:0] md_cnt;
  logic run, mem_wait, load_use, md_stall;
  assign run      = state == RUN;
  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
  assign md_stall = (state == MD_WAIT) && (md_cnt != 8'd0);
  assign md_busy  = ~r & (state == MD_WAIT);
  always_comb begin
    pc_en = 1'b1;
    if_id_en = 1'b1;
    if_id_r = 1'b0;
    id_ex_en = 1'b1;
    id_ex_r = 1'b0;
    ex_mem_en = 1'b1;
    ex_mem_r = 1'b0;
    mem_wb_en = 1'b1;
    mem_wb_r = 1'b0;
    md_go = 1'b0;
    if (r) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_r, id_ex_r, ex_mem_r, mem_wb_r} = '1;
    end else if (run && mem_wait) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
      mem_wb_r = 1'b1;
    end else if (md_stall || (run && ex_md_start)) begin
      {pc_en, if_id_en, id_ex_en} = '0;
      ex_mem_r = 1'b1;
      md_go = run;
    end else if (run && ex_branch_taken) begin
      if_id_r = 1'b1;
      id_ex_r = 1'b1;
    end else if (run && load_use) begin
      pc_en = 1'b0;
      if_id_en = 1'b0;
      id_ex_r = 1'b1;
    end
  end
  // md_cnt counts the stall cycles still owed after the accepting cycle
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state <= RUN;
      md_cnt <= '0;
    end else if (run) begin
      if (!mem_wait && ex_md_start) begin
        state <= MD_WAIT;
        md_cnt <= 8'(MD_CYCLES - 1);
      end
    end else if (md_cnt != 8'd0) begin
      md_cnt <= md_cnt - 8'd1;
    end else begin
      state <= RUN;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(~pc_en);
      flush_cnt <= flush_cnt + CNT_W'(if_id_r);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench with a cycle-time reference model for hazard_ctrl.
module tb_hazard_ctrl;
  localparam int MDC = 4;
  typedef struct packed {
    logic [4:0] rs, rt;
    logic use_rs, use_rt, mr;
    logic [4:0] rd;
    logic br, md, mq, mrdy;
  } in_t;
  typedef struct packed {
    logic [10:0] vec;
    logic [10:0] mask;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic r = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_use_rs = 0, id_use_rt = 0, ex_mem_read = 0, ex_branch_taken = 0;
  logic ex_md_start = 0, mem_req = 0, mem_ready = 0;
  logic pc_en, if_id_en, if_id_r, id_ex_en, id_ex_r, ex_mem_en, ex_mem_r;
  logic mem_wb_en, mem_wb_r, md_go, md_busy;
  int total = 0, bad = 0;
  exp_t sb[$];
  int t = 0, t0 = 0;
  bit in_md = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MD_CYCLES(MDC)) dut (
    .clk(clk), .r(r), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_r(if_id_r), .id_ex_en(id_ex_en), .id_ex_r(id_ex_r), .ex_mem_en(ex_mem_en),
    .ex_mem_r(ex_mem_r), .mem_wb_en(mem_wb_en), .mem_wb_r(mem_wb_r),
    .md_go(md_go), .md_busy(md_busy));
  // Model: a mul/div accepted at cycle t0 stalls through t0+MDC-1 and releases at t0+MDC.
  task automatic step(input in_t v, input bit rv, input bit rmid);
    logic pe, ie, ir, de, dr, ee, er, we, wr, go, bz;
    bit mw, lu;
    exp_t e;
    @(posedge clk);
    #1;
    {id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rd} = {v.rs, v.rt, v.use_rs, v.use_rt, v.mr, v.rd};
    {ex_branch_taken, ex_md_start, mem_req, mem_ready} = {v.br, v.md, v.mq, v.mrdy};
    if (rmid) begin
      #2;
      r = 1'b1;
    end else r = rv;
    mw = v.mq && !v.mrdy;
    lu = v.mr && v.rd != 0 && ((v.use_rs && v.rs == v.rd) || (v.use_rt && v.rt == v.rd));
    {pe, ie, ir, de, dr, ee, er, we, wr, go, bz} = 11'b11010101000;
    if (r) begin
      {pe, ie, ir, de, dr, ee, er, we, wr, go, bz} = 11'b00101010100;
      in_md = 0;
    end else if (in_md) begin
      bz = 1;
      if (t < t0 + MDC) {pe, ie, de, er} = 4'b0001;
      else in_md = 0;
    end else if (mw) begin
      {pe, ie, de, ee, wr} = 5'b00001;
    end else if (v.md) begin
      {pe, ie, de, er, go} = 5'b00011;
      in_md = 1;
      t0 = t;
    end else if (v.br) begin
      {ir, dr} = 2'b11;
    end else if (lu) begin
      {pe, ie, dr} = 3'b001;
    end
    e.vec = {pe, ie, ir, de, dr, ee, er, we, wr, go, bz};
    e.mask = {1'b1, ~ir, 1'b1, ~dr, 1'b1, ~er, 1'b1, ~wr, 1'b1, 1'b1, 1'b1};
    e.cyc = t;
    sb.push_back(e);
    t++;
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [10:0] a;
      e = sb.pop_front();
      a = {pc_en, if_id_en, if_id_r, id_ex_en, id_ex_r, ex_mem_en, ex_mem_r,
           mem_wb_en, mem_wb_r, md_go, md_busy};
      total++;
      if ((a & e.mask) !== (e.vec & e.mask)) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%b want=%b mask=%b", e.cyc, a, e.vec, e.mask);
      end
    end
  end
  function automatic in_t idle();
    in_t v = '0;
    return v;
  endfunction
  initial begin
    in_t v;
    step(idle(), 1, 0);
    step(idle(), 1, 0);
    repeat (2) step(idle(), 0, 0);
    step(idle(), 0, 1);
    step(idle(), 0, 0);
    v = idle(); v.mr = 1; v.rd = 5; v.rs = 5; v.use_rs = 1;
    step(v, 0, 0);
    step(idle(), 0, 0);
    v.rd = 0; v.rs = 0;
    step(v, 0, 0);
    v = idle(); v.mr = 1; v.rd = 7; v.rt = 7; v.use_rt = 1; v.br = 1;
    step(v, 0, 0);
    v = idle(); v.md = 1;
    repeat (6) step(v, 0, 0);
    repeat (2) step(idle(), 0, 0);
    v = idle(); v.md = 1; v.mq = 1;
    repeat (3) step(v, 0, 0);
    v.mrdy = 1;
    step(v, 0, 0);
    repeat (6) step(idle(), 0, 0);
    v = idle(); v.md = 1;
    step(v, 0, 0);
    repeat (2) step(idle(), 0, 0);
    step(idle(), 0, 1);
    repeat (2) step(idle(), 0, 0);
    for (int i = 0; i < 400; i++) begin
      v.rs = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.rd = 5'($urandom_range(0, 3));
      v.use_rs = 1'($urandom_range(0, 1));
      v.use_rt = 1'($urandom_range(0, 1));
      v.mr = 1'($urandom_range(0, 1));
      v.br = $urandom_range(0, 4) == 0;
      v.md = $urandom_range(0, 9) == 0;
      v.mq = $urandom_range(0, 3) == 0;
      v.mrdy = 1'($urandom_range(0, 1));
      step(v, 0, $urandom_range(0, 63) == 0);
    end
    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
